// File: rtl/multicycle_control_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_if
// Bundles every non-clock/reset signal of the multi-cycle control unit.
//   master : the control unit (consumes IR fields and ready strobes, drives
//            datapath selects, write enables and memory/MUL-DIV requests)
//   slave  : the datapath / memory side (the opposite directions)
// Signals:
//   opcode, funct3, funct7_b0         IR fields
//   imem_ready, dmem_ready, md_done   completion strobes
//   take_branch                       branch comparator result
//   imem_req, ir_write                fetch request / IR load
//   dmem_req, dmem_we                 data request / store
//   md_start                          MUL/DIV start pulse
//   pc_write, pc_src                  PC update and source select
//   alu_op, alu_src_a, alu_src_b      ALU controls
//   reg_write, wb_sel                 register write-back
//   rm_type                           latched funct3
//   illegal, state, instret           status / debug
// -----------------------------------------------------------------------------
interface multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             funct7_b0;
    logic             imem_ready;
    logic             dmem_ready;
    logic             md_done;
    logic             take_branch;
    logic             imem_req;
    logic             ir_write;
    logic             dmem_req;
    logic             dmem_we;
    logic             md_start;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic [1:0]       alu_op;
    logic [1:0]       alu_src_a;
    logic             alu_src_b;
    logic             reg_write;
    logic [1:0]       wb_sel;
    logic [2:0]       rm_type;
    logic             illegal;
    logic [2:0]       state;
    logic [CNT_W-1:0] instret;

    modport master (
        input  opcode, funct3, funct7_b0, imem_ready, dmem_ready, md_done, take_branch,
        output imem_req, ir_write, dmem_req, dmem_we, md_start, pc_write, pc_src,
               alu_op, alu_src_a, alu_src_b, reg_write, wb_sel, rm_type, illegal,
               state, instret
    );

    modport slave (
        output opcode, funct3, funct7_b0, imem_ready, dmem_ready, md_done, take_branch,
        input  imem_req, ir_write, dmem_req, dmem_we, md_start, pc_write, pc_src,
               alu_op, alu_src_a, alu_src_b, reg_write, wb_sel, rm_type, illegal,
               state, instret
    );
endinterface

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Multi-cycle RV32I control unit: FETCH -> DECODE -> EXEC -> (MEM) -> (WB),
// with a MULDIV wait state for the optional MUL/DIV unit and an absorbing TRAP
// state for illegal instructions. Outputs are decoded from the current state
// and the instruction class latched in DECODE.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   bus  - multicycle_control_if master modport (IR fields, handshakes,
//          datapath controls, status)
// Parameters:
//   ENABLE_M - 1: R-type with funct7[0]=1 runs on the MUL/DIV unit; 0: illegal
//   CNT_W    - width of the retired-instruction counter
// -----------------------------------------------------------------------------
module multicycle_control #(
    parameter bit ENABLE_M = 1'b0,
    parameter int CNT_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.master bus
);
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_MULDIV = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        CL_NONE   = 4'd0,
        CL_B      = 4'd1,
        CL_R      = 4'd2,
        CL_I      = 4'd3,
        CL_LOAD   = 4'd4,
        CL_STORE  = 4'd5,
        CL_LUI    = 4'd6,
        CL_AUIPC  = 4'd7,
        CL_JAL    = 4'd8,
        CL_JALR   = 4'd9,
        CL_FENCE  = 4'd10,
        CL_MULDIV = 4'd11
    } iclass_t;

    state_t           state_r, next_state_s;
    iclass_t          class_r, dec_class_s;
    logic [2:0]       rm_type_r;
    logic             illegal_r;
    logic             md_first_r;
    logic [CNT_W-1:0] instret_r;
    logic             retire_s;

    logic             imem_req_s, ir_write_s, dmem_req_s, dmem_we_s, md_start_s;
    logic             pc_write_s, alu_src_b_s, reg_write_s;
    logic [1:0]       pc_src_s, alu_op_s, alu_src_a_s, wb_sel_s;

    // ALU controls for a class, packed as {alu_op, alu_src_a, alu_src_b}.
    // Held through MEM/WB so the address / result stays stable.
    function automatic logic [4:0] alu_ctrl(input iclass_t c);
        case (c)
            CL_B:                alu_ctrl = {2'b11, 2'b00, 1'b0};
            CL_R:                alu_ctrl = {2'b10, 2'b00, 1'b0};
            CL_I:                alu_ctrl = {2'b01, 2'b00, 1'b1};
            CL_LOAD, CL_STORE:   alu_ctrl = {2'b00, 2'b00, 1'b1};
            CL_LUI:              alu_ctrl = {2'b00, 2'b10, 1'b1};
            CL_AUIPC:            alu_ctrl = {2'b00, 2'b01, 1'b1};
            CL_JALR:             alu_ctrl = {2'b00, 2'b00, 1'b1};
            default:             alu_ctrl = {2'b00, 2'b00, 1'b0};
        endcase
    endfunction

    // Opcode classification; CL_NONE marks an instruction that must trap.
    always_comb begin
        dec_class_s = CL_NONE;
        case (bus.opcode)
            7'b1100011: dec_class_s = CL_B;
            7'b0110011: begin
                if (!bus.funct7_b0) begin
                    dec_class_s = CL_R;
                end else if (ENABLE_M) begin
                    dec_class_s = CL_MULDIV;
                end else begin
                    dec_class_s = CL_NONE;
                end
            end
            7'b0010011: dec_class_s = CL_I;
            7'b0000011: dec_class_s = CL_LOAD;
            7'b0100011: dec_class_s = CL_STORE;
            7'b0110111: dec_class_s = CL_LUI;
            7'b0010111: dec_class_s = CL_AUIPC;
            7'b1101111: dec_class_s = CL_JAL;
            7'b1100111: dec_class_s = CL_JALR;
            7'b0001111: dec_class_s = CL_FENCE;
            default:    dec_class_s = CL_NONE;
        endcase
    end

    // Next-state and output decode.
    always_comb begin
        next_state_s = state_r;
        imem_req_s   = 1'b0;
        ir_write_s   = 1'b0;
        dmem_req_s   = 1'b0;
        dmem_we_s    = 1'b0;
        md_start_s   = 1'b0;
        pc_write_s   = 1'b0;
        pc_src_s     = 2'b00;
        alu_op_s     = 2'b00;
        alu_src_a_s  = 2'b00;
        alu_src_b_s  = 1'b0;
        reg_write_s  = 1'b0;
        wb_sel_s     = 2'b00;
        if ((state_r == ST_EXEC) || (state_r == ST_MEM) || (state_r == ST_WB)) begin
            {alu_op_s, alu_src_a_s, alu_src_b_s} = alu_ctrl(class_r);
        end else begin
            {alu_op_s, alu_src_a_s, alu_src_b_s} = 5'b00000;
        end
        case (state_r)
            ST_FETCH: begin
                imem_req_s = 1'b1;
                if (bus.imem_ready) begin
                    ir_write_s   = 1'b1;
                    next_state_s = ST_DECODE;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (dec_class_s == CL_NONE) begin
                    next_state_s = ST_TRAP;
                end else if (dec_class_s == CL_MULDIV) begin
                    next_state_s = ST_MULDIV;
                end else begin
                    next_state_s = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (class_r)
                    CL_B: begin
                        pc_write_s   = 1'b1;
                        pc_src_s     = bus.take_branch ? 2'b01 : 2'b00;
                        next_state_s = ST_FETCH;
                    end
                    CL_JAL: begin
                        pc_write_s   = 1'b1;
                        pc_src_s     = 2'b10;
                        next_state_s = ST_WB;
                    end
                    CL_JALR: begin
                        pc_write_s   = 1'b1;
                        pc_src_s     = 2'b11;
                        next_state_s = ST_WB;
                    end
                    CL_LOAD, CL_STORE:           next_state_s = ST_MEM;
                    CL_R, CL_I, CL_LUI, CL_AUIPC: next_state_s = ST_WB;
                    CL_FENCE: begin
                        pc_write_s   = 1'b1;
                        pc_src_s     = 2'b00;
                        next_state_s = ST_FETCH;
                    end
                    // Unreachable class in EXEC: fail safe rather than guess.
                    default:                     next_state_s = ST_TRAP;
                endcase
            end
            ST_MEM: begin
                dmem_req_s = 1'b1;
                dmem_we_s  = (class_r == CL_STORE);
                if (!bus.dmem_ready) begin
                    next_state_s = ST_MEM;
                end else if (class_r == CL_STORE) begin
                    pc_write_s   = 1'b1;
                    pc_src_s     = 2'b00;
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_WB;
                end
            end
            ST_WB: begin
                reg_write_s = 1'b1;
                case (class_r)
                    CL_LOAD:         wb_sel_s = 2'b01;
                    CL_JAL, CL_JALR: wb_sel_s = 2'b10;
                    CL_MULDIV:       wb_sel_s = 2'b11;
                    default:         wb_sel_s = 2'b00;
                endcase
                // Jumps already wrote their target PC in EXEC.
                pc_write_s   = !((class_r == CL_JAL) || (class_r == CL_JALR));
                pc_src_s     = 2'b00;
                next_state_s = ST_FETCH;
            end
            ST_MULDIV: begin
                md_start_s = md_first_r;
                if (bus.md_done) begin
                    next_state_s = ST_WB;
                end else begin
                    next_state_s = ST_MULDIV;
                end
            end
            ST_TRAP:  next_state_s = ST_TRAP;
            default:  next_state_s = ST_FETCH;
        endcase
    end

    assign retire_s = (next_state_s == ST_FETCH) &&
                      ((state_r == ST_EXEC) || (state_r == ST_MEM) || (state_r == ST_WB));

    // State register and per-instruction context.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_FETCH;
            class_r    <= CL_NONE;
            rm_type_r  <= 3'd0;
            md_first_r <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            md_first_r <= (state_r == ST_DECODE) && (next_state_s == ST_MULDIV);
            if (state_r == ST_DECODE) begin
                class_r   <= dec_class_s;
                rm_type_r <= bus.funct3;
            end
        end
    end

    // Sticky illegal flag and retired-instruction counter (wraps naturally).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_r <= 1'b0;
            instret_r <= '0;
        end else begin
            illegal_r <= illegal_r | (next_state_s == ST_TRAP);
            if (retire_s) begin
                instret_r <= instret_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.imem_req  = imem_req_s;
    assign bus.ir_write  = ir_write_s;
    assign bus.dmem_req  = dmem_req_s;
    assign bus.dmem_we   = dmem_we_s;
    assign bus.md_start  = md_start_s;
    assign bus.pc_write  = pc_write_s;
    assign bus.pc_src    = pc_src_s;
    assign bus.alu_op    = alu_op_s;
    assign bus.alu_src_a = alu_src_a_s;
    assign bus.alu_src_b = alu_src_b_s;
    assign bus.reg_write = reg_write_s;
    assign bus.wb_sel    = wb_sel_s;
    assign bus.rm_type   = rm_type_r;
    assign bus.illegal   = illegal_r;
    assign bus.state     = state_r;
    assign bus.instret   = instret_r;
endmodule
